// File: rtl/mmio_uart_tx_if.sv
// Data-memory port bundle between the CPU core and memory-mapped peripherals.
// The core drives address, store strobe and store data; the peripheral answers
// with a combinational select and read data that the top level muxes with RAM.
interface mmio_uart_tx_if;
  logic        mem_write;
  logic [31:0] data_memory_addr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        sel;

  modport master (
    output mem_write,
    output data_memory_addr,
    output write_data,
    input  read_data,
    input  sel
  );

  modport slave (
    input  mem_write,
    input  data_memory_addr,
    input  write_data,
    output read_data,
    output sel
  );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter. Stores to TXDATA queue bytes in a small
// circular FIFO; a four-state FSM pops one byte per frame and shifts it out LSB
// first. STATUS/CTRL reads are combinational so a single-cycle core can use them.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
  parameter int          CLK_DIV    = 16,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  mmio_uart_tx_if.slave bus,
  output logic         tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLK_DIV);
  localparam logic [BW-1:0] BAUD_LAST  = BW'(CLK_DIV - 1);
  localparam logic [AW:0]   COUNT_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nxt;
  logic [BW-1:0] baud, baud_nxt;
  logic [2:0]    bit_cnt, bit_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          pop;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          enable, overflow;

  logic [1:0]    offset;
  logic          push_req, push_ok, ctrl_wr, ovf_set, ovf_clr;
  logic          full, empty;
  logic [31:0]   status;

  assign bus.sel  = (bus.data_memory_addr[31:4] == BASE_ADDR[31:4]);
  assign offset   = bus.data_memory_addr[3:2];
  assign push_req = bus.mem_write && bus.sel && (offset == 2'd0);
  assign ctrl_wr  = bus.mem_write && bus.sel && (offset == 2'd2);
  assign full     = (count == COUNT_FULL);
  assign empty    = (count == '0);
  // A pop in the same cycle frees the slot, so a push at full still lands.
  assign push_ok  = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;
  assign ovf_clr  = ctrl_wr && bus.write_data[1];
  assign status   = {24'd0, 4'(count), overflow, (state != IDLE), empty, full};

  // Register read mux, purely combinational from address and current state
  always_comb begin
    bus.read_data = 32'd0;
    if (bus.sel) begin
      case (offset)
        2'd1:    bus.read_data = status;
        2'd2:    bus.read_data = {31'd0, enable};
        default: bus.read_data = 32'd0;
      endcase
    end
  end

  // Next-state logic for the frame FSM and its baud/bit/shift datapath
  always_comb begin
    state_nxt = state;
    baud_nxt  = baud;
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (enable && !empty) begin
          state_nxt = START;
          pop       = 1'b1;
        end
      end
      START: begin
        if (baud == '0) begin
          state_nxt = DATA;
          baud_nxt  = BAUD_LAST;
        end else begin
          baud_nxt = baud - BW'(1);
        end
      end
      DATA: begin
        if (baud == '0) begin
          baud_nxt = BAUD_LAST;
          if (bit_cnt == 3'd7) begin
            state_nxt = STOP;
          end else begin
            bit_nxt   = bit_cnt + 3'd1;
            shift_nxt = {1'b0, shift[7:1]};
          end
        end else begin
          baud_nxt = baud - BW'(1);
        end
      end
      STOP: begin
        if (baud == '0) begin
          if (enable && !empty) begin
            state_nxt = START;
            pop       = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          baud_nxt = baud - BW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Every frame start loads the head byte and restarts the bit timing.
    if (pop) begin
      shift_nxt = mem[rd_ptr];
      bit_nxt   = 3'd0;
      baud_nxt  = BAUD_LAST;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Baud/bit counters and the registered serial line, driven from next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      baud    <= '0;
      bit_cnt <= 3'd0;
      tx      <= 1'b1;
    end else begin
      baud    <= baud_nxt;
      bit_cnt <= bit_nxt;
      case (state_nxt)
        START:   tx <= 1'b0;
        DATA:    tx <= shift_nxt[0];
        default: tx <= 1'b1;
      endcase
    end
  end

  // Shift register holds payload only; its value is irrelevant until a pop loads it
  always_ff @(posedge clk) begin
    shift <= shift_nxt;
  end

  // FIFO storage array
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= bus.write_data[7:0];
  end

  // FIFO pointers and occupancy counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Control register: enable bit and sticky overflow (clear beats set)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enable   <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (ctrl_wr)      enable   <= bus.write_data[0];
      if (ovf_clr)      overflow <= 1'b0;
      else if (ovf_set) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with CLK_DIV=4: register reads after reset,
// exact single-frame waveform, overflow, push/pop at full, mid-frame reset and
// a streaming run that wraps the FIFO pointers.
module tb_mmio_uart_tx;
  localparam logic [31:0] BASE = 32'hFFFF_0000;
  localparam logic [31:0] A_TX = BASE;
  localparam logic [31:0] A_ST = BASE + 32'd4;
  localparam logic [31:0] A_CT = BASE + 32'd8;
  localparam logic [31:0] A_RS = BASE + 32'hC;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tx;
  int   total = 0;
  int   bad = 0;

  mmio_uart_tx_if bus ();

  mmio_uart_tx #(.BASE_ADDR(BASE), .CLK_DIV(4), .FIFO_DEPTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .tx    (tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic reg_wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.mem_write = 1'b1;
    bus.data_memory_addr = a;
    bus.write_data = d;
    @(posedge clk);
    #1;
    bus.mem_write = 1'b0;
    bus.write_data = 32'd0;
  endtask

  task automatic rd_now(input logic [31:0] a, output logic [31:0] v);
    bus.data_memory_addr = a;
    #1;
    v = bus.read_data;
  endtask

  task automatic reg_rd(input logic [31:0] a, output logic [31:0] v);
    @(negedge clk);
    rd_now(a, v);
  endtask

  // Waits for a start bit, samples mid-bit, returns in the last stop cycle.
  task automatic rx_byte(output logic [7:0] b, output int waited);
    waited = 0;
    b = 8'd0;
    for (int i = 1; i <= 600; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        waited = i;
        break;
      end
    end
    if (waited == 0) return;
    repeat (6) @(negedge clk);
    b[0] = tx;
    for (int j = 1; j < 8; j++) begin
      repeat (4) @(negedge clk);
      b[j] = tx;
    end
    repeat (4) @(negedge clk);
    chk("stop_bit", 32'(tx), 32'd1);
    @(negedge clk);
  endtask

  task automatic count_lows(input int cycles, output int lows);
    lows = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
  endtask

  initial begin
    logic [31:0] v;
    logic [7:0]  b;
    logic [7:0]  pat;
    int          w;
    int          lows;
    int          got;
    int          saw_full;
    logic        expb;

    bus.mem_write = 1'b0;
    bus.data_memory_addr = 32'd0;
    bus.write_data = 32'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", 32'(tx), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    reg_rd(A_ST, v);  chk("rst_status", v, 32'h2);
    rd_now(A_CT, v);  chk("rst_ctrl", v, 32'h1);
    rd_now(A_TX, v);  chk("rd_txdata", v, 32'h0);
    rd_now(A_RS, v);  chk("rd_rsvd", v, 32'h0);
    rd_now(32'h0000_0100, v);
    chk("sel_off", 32'(bus.sel), 32'd0);
    chk("rd_off", v, 32'h0);
    rd_now(BASE + 32'h5, v);
    chk("sel_on", 32'(bus.sel), 32'd1);
    chk("rd_lowbits", v, 32'h2);

    // Single byte 0x55, exact waveform
    pat = 8'h55;
    reg_wr(A_TX, 32'h55);
    reg_rd(A_ST, v);  chk("one_status_pushed", v, 32'h10);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c < 4)       expb = 1'b0;
      else if (c < 36) expb = pat[(c - 4) / 4];
      else             expb = 1'b1;
      chk($sformatf("one_tx_c%0d", c), 32'(tx), 32'(expb));
      if (c == 0 || c == 39) begin
        rd_now(A_ST, v);
        chk("one_status_busy", v, 32'h6);
      end
    end
    reg_rd(A_ST, v);  chk("one_status_done", v, 32'h2);

    // Overflow with transmitter disabled
    reg_wr(A_CT, 32'h0);
    for (int i = 0; i < 9; i++) reg_wr(A_TX, 32'(i));
    reg_rd(A_ST, v);  chk("ovf_status", v, 32'h89);
    chk("ovf_tx_idle", 32'(tx), 32'd1);
    reg_wr(A_CT, 32'h3);
    reg_rd(A_ST, v);  chk("ovf_cleared", v, 32'h81);
    for (int i = 0; i < 8; i++) begin
      rx_byte(b, w);
      chk($sformatf("ovf_data%0d", i), 32'(b), 32'(i));
      if (i == 0) chk("ovf_first_seen", 32'(w != 0), 32'd1);
      else        chk($sformatf("ovf_gap%0d", i), 32'(w), 32'd1);
    end
    count_lows(60, lows);
    chk("ovf_no_ninth", 32'(lows), 32'd0);
    reg_rd(A_ST, v);  chk("ovf_final", v, 32'h2);

    // Push in the same cycle as the first pop while full
    reg_wr(A_CT, 32'h0);
    for (int i = 0; i < 8; i++) reg_wr(A_TX, 32'h30 + 32'(i));
    reg_wr(A_CT, 32'h1);
    reg_wr(A_TX, 32'h38);
    rd_now(A_ST, v);  chk("pp_status", v, 32'h85);
    for (int i = 0; i < 9; i++) begin
      rx_byte(b, w);
      chk($sformatf("pp_data%0d", i), 32'(b), 32'h30 + 32'(i));
      if (i == 0) chk("pp_first_seen", 32'(w != 0), 32'd1);
      else        chk($sformatf("pp_gap%0d", i), 32'(w), 32'd1);
    end
    reg_rd(A_ST, v);  chk("pp_final", v, 32'h2);

    // Reset during data bit 3 of 0xA5 with three bytes queued
    reg_wr(A_CT, 32'h0);
    reg_wr(A_TX, 32'hA5);
    reg_wr(A_TX, 32'h11);
    reg_wr(A_TX, 32'h22);
    reg_wr(A_TX, 32'h33);
    reg_wr(A_CT, 32'h1);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        got = 1;
        break;
      end
    end
    chk("mr_start_seen", 32'(got), 32'd1);
    repeat (17) @(negedge clk);
    chk("mr_bit3", 32'(tx), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    chk("mr_tx_high", 32'(tx), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    reg_rd(A_ST, v);  chk("mr_status", v, 32'h2);
    rd_now(A_CT, v);  chk("mr_ctrl", v, 32'h1);
    count_lows(100, lows);
    chk("mr_silent", 32'(lows), 32'd0);

    // Streaming 20 bytes across pointer wrap
    saw_full = 0;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          logic [31:0] st;
          int ok;
          ok = 0;
          for (int t = 0; t < 200; t++) begin
            reg_rd(A_ST, st);
            chk("wrap_full_flag", 32'(st[0]), 32'(st[7:4] == 4'd8));
            chk("wrap_empty_flag", 32'(st[1]), 32'(st[7:4] == 4'd0));
            if (st[0]) saw_full = 1;
            else begin
              ok = 1;
              break;
            end
          end
          chk("wrap_push_wait", 32'(ok), 32'd1);
          reg_wr(A_TX, 32'h10 + 32'(i));
        end
      end
      begin
        for (int i = 0; i < 20; i++) begin
          logic [7:0] rb;
          int rw;
          rx_byte(rb, rw);
          chk($sformatf("wrap_data%0d", i), 32'(rb), 32'h10 + 32'(i));
        end
      end
    join
    chk("wrap_saw_full", 32'(saw_full), 32'd1);
    reg_rd(A_ST, v);  chk("wrap_final", v, 32'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter on the CPU data-memory port, downstream of the ARM core. It decodes store/load accesses on `data_memory_addr`, queues store bytes in an 8-entry TX FIFO, and serialises them as 8N1 frames on `tx`. Status reads return combinationally on `read_data` in the same cycle, as the single-cycle core requires; the top level muxes `read_data` with data RAM using `sel`.

## Interface
- `BASE_ADDR`, default 32'hFFFF_0000: 16-byte-aligned base of the register window.
- `CLK_DIV`, default 16: clocks per serial bit, ≥2.
- `FIFO_DEPTH`, default 8: TX FIFO entries, power of two.
- `clk` in 1: system clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low (0 = reset).
- `mem_write` in 1: store strobe from core.
- `data_memory_addr` in 32: byte address from core.
- `write_data` in 32: store data from core.
- `read_data` out 32: combinational register read data, 0 when not selected.
- `sel` out 1: combinational, 1 when `data_memory_addr[31:4] == BASE_ADDR[31:4]`.
- `tx` out 1: serial line, idle high.

## Operation
- Register offsets use `addr[3:2]`; `addr[1:0]` is ignored.
  - 0x0 TXDATA: a write pushes `write_data[7:0]`; reads return 0.
  - 0x4 STATUS, read-only: bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky), bits[7:4] FIFO count (0..8), other bits 0.
  - 0x8 CTRL: bit0 enable (read/write); writing 1 to bit1 clears overflow (reads as 0).
  - 0xC: reads 0; writes are ignored.
- A push happens when `mem_write && sel && offset==0`.
  - Push while full with no pop that cycle: the byte is dropped and overflow is set to 1.
  - Push and pop in the same cycle: both take effect; count is unchanged, including when full.
  - An overflow set and a CTRL clear in the same cycle: clear wins.
- FIFO is circular; read/write pointers wrap modulo FIFO_DEPTH. Count is a separate counter, width log2(FIFO_DEPTH)+1.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE→START when enable=1 and FIFO non-empty. That edge pops the head into an 8-bit shift register and clears the bit counter.
  - START: drives `tx`=0 for CLK_DIV cycles, then →DATA.
  - DATA: drives shift[0], LSB first. Each bit lasts CLK_DIV cycles, then the register shifts right. After the 8th bit →STOP.
  - STOP: drives `tx`=1 for CLK_DIV cycles. Then →START with an immediate pop if enable=1 and FIFO is non-empty; otherwise →IDLE.
- Baud counter is loaded with CLK_DIV-1 on each state/bit entry and decrements; the bit ends when it reaches 0.
- Clearing enable mid-frame does not abort the frame. The FSM finishes STOP, then stays IDLE.
- `tx` is registered: 1 in IDLE/STOP, 0 in START, shift[0] in DATA.

## Timing
- Reset (asynchronous assert) forces:
  - `tx`=1, FSM=IDLE
  - FIFO empty, count=0, pointers=0
  - overflow=0, enable=1
  - baud and bit counters 0
- Reset mid-frame aborts immediately and `tx` goes high; queued bytes are lost.
- `read_data` and `sel` are purely combinational from the address and current state; a write is not visible in a read until the next cycle.
- Push at edge N → count and STATUS updated from cycle N+1.
- FIFO non-empty at edge N while IDLE with enable=1 → `tx` falls after edge N+1.
  - If the push happened at edge N, the start bit falls after edge N+1; STATUS shows busy from N+2.
- Frame length: exactly 10·CLK_DIV cycles. Back-to-back frames have no idle gap.
- Frame start pops at the IDLE→START or STOP→START edge, so the FIFO frees one slot at each frame start.

## Test plan
- Reset, CLK_DIV=4:
  - Response: `tx`=1, STATUS read = 0x0000_0002, CTRL read = 0x1, `sel`=0 for address 0x0000_0100.
- Single byte: store 0x55 to BASE+0.
  - Response: `tx` low for 4 cycles, then bits 1,0,1,0,1,0,1,0 for 4 cycles each, then high for 4.
  - Busy clears 40 cycles after the start bit; STATUS returns 0x2.
- Overflow: disable (CTRL=0), push 9 bytes 0x00..0x08.
  - Response: STATUS = 0x0000_0089 (count 8, full, overflow).
  - Write CTRL=0x3 → overflow clears. Bytes 0x00..0x07 are sent back-to-back: 80·CLK_DIV cycles with no idle bit between frames, and 0x08 is never sent.
- Simultaneous push/pop at full:
  - Setup: disable, fill 8 bytes, enable, push in the exact cycle of the first pop.
  - Response: count stays 8, overflow stays 0, and all 9 bytes are transmitted in order.
- Reset mid-frame: assert reset during the DATA bit 3 of 0xA5 with 3 bytes queued.
  - Response: `tx`=1 immediately; after release STATUS = 0x2 and no further frames are sent.
- Pointer wrap: stream 20 bytes 0x10..0x23, pushing whenever not full.
  - Response: the serial output decodes to exactly 0x10..0x23 in order; full and empty flags are correct across the pointer wrap.
